// File: rtl/vga_frame_fetch.sv
// Frame-fetch sequencer: issues one frame of sequential framebuffer reads and pushes the
// returned words into the pixel FIFO. It throttles on FIFO almost-full and on a bounded
// count of outstanding reads, so the FIFO cannot be overrun by data already in flight.
module vga_frame_fetch #(
    parameter int unsigned AW          = 19,
    parameter int unsigned DW          = 16,
    parameter int unsigned FRAME_WORDS = 307200,
    parameter int unsigned MAX_OUTST   = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          enable_i,
    input  logic          frame_start_i,
    input  logic [AW-1:0] base_addr_i,
    output logic          mem_req_o,
    output logic [AW-1:0] mem_addr_o,
    input  logic          mem_ready_i,
    input  logic          mem_rvalid_i,
    input  logic [DW-1:0] mem_rdata_i,
    output logic          fifo_write_o,
    output logic [DW-1:0] fifo_din_o,
    input  logic          fifo_afull_i,
    input  logic          fifo_full_i,
    output logic          busy_o,
    output logic          frame_done_o,
    output logic          late_err_o,
    output logic          ovf_err_o
);

    localparam int unsigned CW = $clog2(FRAME_WORDS + 1);
    localparam int unsigned OW = $clog2(MAX_OUTST + 1);
    localparam logic [CW-1:0] FrameWordsC = CW'(FRAME_WORDS);
    localparam logic [OW-1:0] MaxOutstC   = OW'(MAX_OUTST);

    typedef enum logic [1:0] {StIdle, StFetch, StDrain} state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [CW-1:0] req_cnt_q, req_cnt_d;
    logic [OW-1:0] outst_q, outst_d;
    logic          mem_req_q, mem_req_d;
    logic          fifo_write_q, fifo_write_d;
    logic [DW-1:0] fifo_din_q, fifo_din_d;
    logic          frame_done_q, frame_done_d;
    logic          late_err_q, late_err_d;

    logic accept;
    logic ret;
    logic hold;

    assign accept = mem_req_q & mem_ready_i;
    // Returns with nothing outstanding belong to requests issued before a reset.
    assign ret    = mem_rvalid_i & (outst_q != '0);
    // A raised request must stay up, with a stable address, until the memory takes it.
    assign hold   = mem_req_q & ~mem_ready_i;

    // Next-state, request issue and return-path logic.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        req_cnt_d    = req_cnt_q;
        mem_req_d    = 1'b0;
        frame_done_d = 1'b0;
        outst_d      = outst_q + OW'(accept) - OW'(ret);
        fifo_write_d = ret;
        fifo_din_d   = ret ? mem_rdata_i : fifo_din_q;
        late_err_d   = frame_start_i & (state_q != StIdle);

        unique case (state_q)
            StIdle: begin
                if (frame_start_i && enable_i) begin
                    state_d   = StFetch;
                    addr_d    = base_addr_i;
                    req_cnt_d = '0;
                end
            end
            StFetch: begin
                if (accept) begin
                    addr_d    = addr_q + AW'(1);
                    req_cnt_d = req_cnt_q + CW'(1);
                end
                if (hold) begin
                    mem_req_d = 1'b1;
                end else if ((req_cnt_d == FrameWordsC) || !enable_i) begin
                    state_d = StDrain;
                end else begin
                    // outst_d already counts this cycle's accept, allowing 1 request/cycle.
                    mem_req_d = (outst_d < MaxOutstC) & ~fifo_afull_i;
                end
            end
            StDrain: begin
                if (outst_q == '0) begin
                    state_d      = StIdle;
                    frame_done_d = (req_cnt_q == FrameWordsC);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and output registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            addr_q       <= '0;
            req_cnt_q    <= '0;
            outst_q      <= '0;
            mem_req_q    <= 1'b0;
            fifo_write_q <= 1'b0;
            fifo_din_q   <= '0;
            frame_done_q <= 1'b0;
            late_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            req_cnt_q    <= req_cnt_d;
            outst_q      <= outst_d;
            mem_req_q    <= mem_req_d;
            fifo_write_q <= fifo_write_d;
            fifo_din_q   <= fifo_din_d;
            frame_done_q <= frame_done_d;
            late_err_q   <= late_err_d;
        end
    end

    assign mem_req_o    = mem_req_q;
    assign mem_addr_o   = addr_q;
    assign fifo_write_o = fifo_write_q;
    assign fifo_din_o   = fifo_din_q;
    assign busy_o       = (state_q != StIdle);
    assign frame_done_o = frame_done_q;
    assign late_err_o   = late_err_q;
    // The write is still presented; the FIFO drops it and this flags the loss.
    assign ovf_err_o    = fifo_write_q & fifo_full_i;

endmodule

// File: tb/tb_vga_frame_fetch.sv
// Scoreboard bench for vga_frame_fetch: a memory model issues random read data, a reference
// tracks expected addresses and outstanding reads, and a monitor checks FIFO writes in order.
module tb_vga_frame_fetch;

    localparam int unsigned AW = 19;
    localparam int unsigned DW = 16;
    localparam int unsigned FW = 8;
    localparam int unsigned MO = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          enable = 1'b0;
    logic          frame_start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic          mem_ready = 1'b0;
    logic          mem_rvalid = 1'b0;
    logic [DW-1:0] mem_rdata = '0;
    logic          fifo_write;
    logic [DW-1:0] fifo_din;
    logic          fifo_afull = 1'b0;
    logic          fifo_full = 1'b0;
    logic          busy, frame_done, late_err, ovf_err;

    vga_frame_fetch #(.AW(AW), .DW(DW), .FRAME_WORDS(FW), .MAX_OUTST(MO)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable_i     (enable),
        .frame_start_i(frame_start),
        .base_addr_i  (base_addr),
        .mem_req_o    (mem_req),
        .mem_addr_o   (mem_addr),
        .mem_ready_i  (mem_ready),
        .mem_rvalid_i (mem_rvalid),
        .mem_rdata_i  (mem_rdata),
        .fifo_write_o (fifo_write),
        .fifo_din_o   (fifo_din),
        .fifo_afull_i (fifo_afull),
        .fifo_full_i  (fifo_full),
        .busy_o       (busy),
        .frame_done_o (frame_done),
        .late_err_o   (late_err),
        .ovf_err_o    (ovf_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // Memory model knobs, set by the main sequence.
    bit ready_rand  = 0;
    int stall_first = 0;
    int lat_min     = 2;
    int lat_max     = 2;
    bit mem_hold    = 0;
    int release_cnt = 0;

    // Reference state.
    typedef struct {
        logic [DW-1:0] data;
        int            due;
    } ret_t;
    ret_t          pend[$];
    logic [DW-1:0] exp_q[$];
    logic [AW-1:0] exp_addr = '0;
    int            model_outst = 0;
    int            acc_cnt = 0;
    int            stall_cyc = 0;
    int            cyc = 0;
    bit            prev_stall = 0;
    logic [AW-1:0] prev_addr = '0;

    // Memory side: runs a little after the falling edge so the main sequence has driven inputs.
    always @(negedge clk) begin
        bit          acc;
        bit          rt;
        logic [DW-1:0] d;
        #2;
        cyc++;
        if (!rst_n) begin
            model_outst = 0;
            exp_q.delete();
            mem_ready   = 1'b0;
            mem_rvalid  = 1'b0;
            prev_stall  = 0;
        end else begin
            if (frame_start && enable && !busy) exp_addr = base_addr;
            if (prev_stall) begin
                check("req_held", mem_req, 1);
                check("addr_held", mem_addr, prev_addr);
            end
            mem_rvalid = 1'b0;
            if (pend.size() > 0 && pend[0].due <= cyc && (!mem_hold || release_cnt > 0)) begin
                if (mem_hold) release_cnt--;
                mem_rvalid = 1'b1;
                mem_rdata  = pend[0].data;
                void'(pend.pop_front());
            end
            if (mem_req && stall_first > 0) begin
                mem_ready = 1'b0;
                stall_first--;
            end else begin
                mem_ready = ready_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
            end
            acc = mem_req && mem_ready;
            rt  = mem_rvalid && model_outst > 0;
            if (mem_req && !mem_ready) stall_cyc++;
            if (acc) begin
                check("mem_addr", mem_addr, exp_addr);
                exp_addr = exp_addr + 1'b1;
                acc_cnt++;
                d = DW'($urandom);
                pend.push_back('{data: d, due: cyc + int'($urandom_range(lat_min, lat_max))});
            end
            if (rt) exp_q.push_back(mem_rdata);
            model_outst = model_outst + int'(acc) - int'(rt);
            if (acc) check("outst_bound", model_outst <= MO, 1);
            prev_stall = mem_req && !mem_ready;
            prev_addr  = mem_addr;
        end
    end

    // Monitor: pops the scoreboard on every FIFO write.
    int            wr_cnt = 0;
    int            done_cnt = 0;
    int            late_cnt = 0;
    bit            prev_wr = 0;
    logic [DW-1:0] last_din = '0;

    always @(posedge clk) begin
        #1;
        if (!rst_n) begin
            prev_wr = 0;
        end else begin
            if (fifo_write) begin
                wr_cnt++;
                if (exp_q.size() == 0) check("spurious_write", fifo_write, 0);
                else check("fifo_din", fifo_din, exp_q.pop_front());
                check("ovf_err", ovf_err, fifo_full);
                last_din = fifo_din;
            end else if (prev_wr) begin
                check("din_hold", fifo_din, last_din);
            end
            if (frame_done) done_cnt++;
            if (late_err) late_cnt++;
            prev_wr = fifo_write;
        end
    end

    task automatic start_frame(input logic [AW-1:0] base);
        @(negedge clk);
        base_addr   = base;
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
    endtask

    task automatic wait_idle(input bit rnd);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
            if (rnd) begin
                fifo_afull = ($urandom_range(0, 3) == 0);
                fifo_full  = ($urandom_range(0, 5) == 0);
            end
        end while (busy && n < 500);
        fifo_afull = 1'b0;
        fifo_full  = 1'b0;
        check("idle_timeout", busy, 0);
    endtask

    task automatic wait_acc(input int a0, input int target);
        int n = 0;
        while ((acc_cnt - a0) < target && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("acc_timeout", (acc_cnt - a0) >= target, 1);
    endtask

    task automatic check_frame(input string tag, input int a0, input int w0, input int d0);
        check({tag, "_accepts"}, acc_cnt - a0, FW);
        check({tag, "_writes"}, wr_cnt - w0, FW);
        check({tag, "_done"}, done_cnt - d0, 1);
        check({tag, "_sb_empty"}, exp_q.size(), 0);
    endtask

    initial begin
        int a0, w0, d0, l0, a1;
        int n;

        repeat (3) @(negedge clk);
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_fifo_write", fifo_write, 0);
        check("rst_fifo_din", fifo_din, 0);
        check("rst_busy", busy, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_late_err", late_err, 0);
        check("rst_ovf_err", ovf_err, 0);
        rst_n  = 1'b1;
        enable = 1'b1;
        repeat (2) @(negedge clk);

        // Basic frame.
        a0 = acc_cnt; w0 = wr_cnt; d0 = done_cnt;
        start_frame(19'h100);
        wait_idle(0);
        check_frame("basic", a0, w0, d0);

        // First request stalled for 5 cycles, FIFO reporting full throughout.
        a0 = acc_cnt; w0 = wr_cnt; d0 = done_cnt;
        stall_cyc   = 0;
        stall_first = 5;
        fifo_full   = 1'b1;
        start_frame(19'h2345);
        n = 0;
        while (busy && n < 500) begin
            @(negedge clk);
            fifo_full = 1'b1;
            n++;
        end
        fifo_full = 1'b0;
        check("stall_cycles", stall_cyc, 5);
        check_frame("stall", a0, w0, d0);

        // Memory withholds data: issue must stop at the outstanding limit.
        a0 = acc_cnt; w0 = wr_cnt; d0 = done_cnt;
        mem_hold = 1;
        start_frame(19'h40);
        repeat (30) @(negedge clk);
        check("outst_cap_accepts", acc_cnt - a0, MO);
        check("outst_cap_req_low", mem_req, 0);
        release_cnt = 1;
        repeat (10) @(negedge clk);
        check("outst_release_one", acc_cnt - a0, MO + 1);
        mem_hold = 0;
        wait_idle(0);
        check_frame("outst", a0, w0, d0);

        // Almost-full pauses issue mid-frame.
        a0 = acc_cnt; w0 = wr_cnt; d0 = done_cnt;
        start_frame(19'h1000);
        wait_acc(a0, 3);
        fifo_afull = 1'b1;
        repeat (2) @(negedge clk);
        a1 = acc_cnt;
        repeat (10) @(negedge clk);
        check("afull_no_accept", acc_cnt, a1);
        check("afull_req_low", mem_req, 0);
        fifo_afull = 1'b0;
        wait_idle(0);
        check_frame("afull", a0, w0, d0);

        // Late frame_start is flagged and ignored.
        a0 = acc_cnt; w0 = wr_cnt; d0 = done_cnt; l0 = late_cnt;
        start_frame(19'h3000);
        wait_acc(a0, 2);
        start_frame(19'h5555);
        repeat (3) @(negedge clk);
        check("late_err_pulses", late_cnt - l0, 1);
        wait_idle(0);
        check_frame("late", a0, w0, d0);

        // Enable dropped mid-frame: drains, no frame_done.
        a0 = acc_cnt; w0 = wr_cnt; d0 = done_cnt;
        start_frame(19'h6000);
        wait_acc(a0, 3);
        enable = 1'b0;
        wait_idle(0);
        check("abort_no_done", done_cnt - d0, 0);
        check("abort_partial", (acc_cnt - a0) < FW, 1);
        check("abort_drained", wr_cnt - w0, acc_cnt - a0);
        enable = 1'b1;

        // Randomised frames, including an address wrap.
        ready_rand = 1;
        lat_min    = 1;
        lat_max    = 5;
        for (int f = 0; f < 4; f++) begin
            a0 = acc_cnt; w0 = wr_cnt; d0 = done_cnt;
            start_frame(f == 0 ? 19'h7fffc : AW'($urandom));
            wait_idle(1);
            check_frame("rand", a0, w0, d0);
        end
        ready_rand = 0;
        lat_min    = 2;
        lat_max    = 2;

        // Reset with three reads outstanding; stale returns must be dropped.
        mem_hold = 1;
        a0 = acc_cnt;
        start_frame(19'h200);
        n = 0;
        do begin
            @(negedge clk);
            #3;
            n++;
        end while (model_outst < 3 && n < 50);
        check("outst_reached_3", model_outst, 3);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_mem_req", mem_req, 0);
        check("arst_mem_addr", mem_addr, 0);
        check("arst_fifo_write", fifo_write, 0);
        check("arst_busy", busy, 0);
        check("arst_fifo_din", fifo_din, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n    = 1'b1;
        w0       = wr_cnt;
        mem_hold = 0;
        repeat (15) @(negedge clk);
        check("stale_no_write", wr_cnt, w0);
        check("stale_idle", busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
